ntt_ram_sched: RTL
==================

NTT_RAM_SCHED -- requirements
Module: ntt_ram_sched

Interface
REQ-001 Parameter: BF_LAT, 4, butterfly pipeline latency in cycles from bf_in_valid to the result on the RAM data ports; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to run a full transform; honoured only in IDLE.
REQ-005 inv  input  1  0 = forward NTT, 1 = inverse NTT; sampled on the cycle start is accepted.
REQ-006 addr_a  output  8  RAM port A address (even/low coefficient of the pair).
REQ-007 addr_b  output  8  RAM port B address (odd/high coefficient, addr_a + len).
REQ-008 we_a  output  1  RAM port A write enable.
REQ-009 we_b  output  1  RAM port B write enable.
REQ-010 bf_in_valid  output  1  RAM read data (q_a, q_b) is valid for the butterfly this cycle.
REQ-011 zeta_idx  output  7  twiddle ROM index for the current butterfly.
REQ-012 busy  output  1  high from the first READ through the final WRITE.
REQ-013 done  output  1  one-cycle pulse after the final write-back.

Function
REQ-014 FSM states SHALL be IDLE, READ, WAIT, WRITE and DONE.
REQ-015 IDLE -> READ on start=1; start in any other state SHALL be ignored.
REQ-016 READ lasts 1 cycle: drive the pair addresses with we_a=we_b=0.
REQ-017 READ -> WAIT; the cycle after READ SHALL assert bf_in_valid=1 for exactly one cycle; WAIT lasts BF_LAT cycles with addresses held and we low.
REQ-018 WRITE lasts 1 cycle: same addresses as the preceding READ, we_a=we_b=1.
REQ-019 WRITE -> READ of the next butterfly, or -> DONE after the 896th butterfly; DONE -> IDLE after 1 cycle, with done=1 during DONE.
REQ-020 Butterfly period SHALL be BF_LAT+2 cycles; start accepted in cycle 0 gives first READ in cycle 1 and done in cycle 896*(BF_LAT+2)+1.
REQ-021 Forward order: len = 128,64,...,2 (7 layers); within a layer, groups start = 0, 2*len, ... < 256; within a group, j = start..start+len-1; addr_a=j, addr_b=j+len.
REQ-022 Inverse order: len = 2,4,...,128; group and j ordering as in REQ-021.
REQ-023 zeta_idx SHALL start at 1 (forward) or 127 (inverse) and step +1 (forward) or -1 (inverse) at each group boundary; 127 groups total; it is constant within a group.
REQ-024 Address arithmetic is 8-bit unsigned; j+len never exceeds 255, so addr_a != addr_b holds always and no port collision occurs.
REQ-025 busy=1 in READ, WAIT and WRITE; 0 in IDLE and DONE.
REQ-026 In IDLE and DONE: addr_a=addr_b=0, we low, bf_in_valid=0, zeta_idx held.

Reset
REQ-027 rst_n=0 SHALL force IDLE immediately, even mid-transform; no pending write completes.
REQ-028 Reset values: addr_a=0, addr_b=0, we_a=0, we_b=0, bf_in_valid=0, zeta_idx=0, busy=0, done=0; inv latch=0; all counters=0.

Structure
REQ-029 Shared package ntt_pkg SHALL hold N=256, LOG_N=8, LAYERS=7, COEF_W=12, the FSM state enum, and the butterfly count 896.
REQ-030 Layer, group and offset counters with address/zeta generation SHALL be a sub-module, ntt_addr_gen, advanced by a one-cycle step strobe from the FSM.

Verification
REQ-031 Forward start, BF_LAT=4 -> first READ at cycle 1: addr (0,128), zeta_idx 1; WRITE at cycle 6 to (0,128); second READ at cycle 7: (1,129).
REQ-032 Forward layer boundary -> butterfly 129 reads (0,64) with zeta_idx 2; butterfly 193 reads (128,192) with zeta_idx 3.
REQ-033 Forward last butterfly -> reads (253,255) with zeta_idx 127; done pulses at cycle 5377; busy falls at the same edge.
REQ-034 Inverse start -> butterflies (0,2),(1,3) at zeta_idx 127, then (4,6) at 126; final layer (0..127, +128) at zeta_idx 1.
REQ-035 start re-pulsed while busy -> ignored, done still at cycle 5377; rst_n low during WAIT -> we never asserts, all outputs at reset values, new start runs normally.
REQ-036 Scoreboard over a full run -> each address is written exactly 7 times and we_a, we_b are never high outside WRITE.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants and FSM state encoding for the NTT RAM scheduler.
package ntt_pkg;

  localparam int N      = 256;
  localparam int LOG_N  = 8;
  localparam int LAYERS = 7;
  localparam int COEF_W = 12;
  localparam int NUM_BF = 896;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/ntt_addr_gen.sv
// Group/offset/length counters producing butterfly pair addresses and twiddle index.
module ntt_addr_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_i,
  input  logic       inv_i,
  input  logic       step_i,
  output logic [7:0] addr_a_o,
  output logic [7:0] addr_b_o,
  output logic [6:0] zeta_o
);

  logic       dir_q, dir_d;
  logic [7:0] len_q, len_d;
  logic [8:0] grp_q, grp_d;
  logic [7:0] off_q, off_d;
  logic [6:0] zeta_q, zeta_d;
  logic [8:0] grp_next_s;

  assign addr_a_o = grp_q[7:0] + off_q;
  assign addr_b_o = addr_a_o + len_q;
  assign zeta_o   = zeta_q;

  // Next-state: load the first butterfly of a run, or advance within group/layer
  always_comb begin
    dir_d      = dir_q;
    len_d      = len_q;
    grp_d      = grp_q;
    off_d      = off_q;
    zeta_d     = zeta_q;
    grp_next_s = grp_q + {len_q, 1'b0};
    if (init_i) begin
      dir_d  = inv_i;
      len_d  = inv_i ? 8'd2 : 8'd128;
      grp_d  = 9'd0;
      off_d  = 8'd0;
      zeta_d = inv_i ? 7'd127 : 7'd1;
    end else if (step_i) begin
      if (off_q + 8'd1 == len_q) begin
        off_d  = 8'd0;
        zeta_d = dir_q ? zeta_q - 7'd1 : zeta_q + 7'd1;
        // grp_next reaching 256 marks the end of a layer
        if (grp_next_s[8]) begin
          grp_d = 9'd0;
          len_d = dir_q ? {len_q[6:0], 1'b0} : {1'b0, len_q[7:1]};
        end else begin
          grp_d = grp_next_s;
        end
      end else begin
        off_d = off_q + 8'd1;
      end
    end else begin
      off_d = off_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q  <= 1'b0;
      len_q  <= 8'd0;
      grp_q  <= 9'd0;
      off_q  <= 8'd0;
      zeta_q <= 7'd0;
    end else begin
      dir_q  <= dir_d;
      len_q  <= len_d;
      grp_q  <= grp_d;
      off_q  <= off_d;
      zeta_q <= zeta_d;
    end
  end

endmodule

// File: rtl/ntt_ram_sched.sv
// In-place NTT/INTT RAM scheduler: READ, WAIT(BF_LAT), WRITE per butterfly, 896 butterflies.
module ntt_ram_sched
  import ntt_pkg::*;
#(
  parameter int BF_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       inv,
  output logic [7:0] addr_a,
  output logic [7:0] addr_b,
  output logic       we_a,
  output logic       we_b,
  output logic       bf_in_valid,
  output logic [6:0] zeta_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] WAIT_LAST = 4'(BF_LAT - 1);
  localparam logic [9:0] LAST_BF   = 10'(NUM_BF - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [9:0] bf_q, bf_d;
  logic       init_s, step_s;
  logic [7:0] gen_a_s, gen_b_s;

  ntt_addr_gen u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_i   (init_s),
    .inv_i    (inv),
    .step_i   (step_s),
    .addr_a_o (gen_a_s),
    .addr_b_o (gen_b_s),
    .zeta_o   (zeta_idx)
  );

  // Outputs are pure decodes of the state and counter registers
  assign busy        = (state_q == ST_READ) || (state_q == ST_WAIT) || (state_q == ST_WRITE);
  assign done        = (state_q == ST_DONE);
  assign we_a        = (state_q == ST_WRITE);
  assign we_b        = (state_q == ST_WRITE);
  assign bf_in_valid = (state_q == ST_WAIT) && (wait_q == 4'd0);
  assign addr_a      = busy ? gen_a_s : 8'd0;
  assign addr_b      = busy ? gen_b_s : 8'd0;

  // FSM next-state and counter control
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bf_d    = bf_q;
    init_s  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          init_s  = 1'b1;
          bf_d    = 10'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
        wait_d  = 4'd0;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_WRITE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      ST_WRITE: begin
        // Counters are not stepped past the final butterfly so zeta_idx holds
        if (bf_q == LAST_BF) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
          step_s  = 1'b1;
          bf_d    = bf_q + 10'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
      bf_q    <= 10'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bf_q    <= bf_d;
    end
  end

endmodule
